// File: rtl/mux2_rr_arbiter.sv
// Two-source round-robin arbiter feeding a registered output beat; owner change costs one idle cycle except direct A<->B hand-off.
// Latency valid->y is 2 cycles from IDLE, 1 cycle while owning; y_valid & ~y_ready holds y and drops the owner's ready.
module mux2_rr_arbiter #(
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a_valid,
   input  logic [WIDTH-1:0] a_data,
   output logic             a_ready,
   input  logic             b_valid,
   input  logic [WIDTH-1:0] b_data,
   output logic             b_ready,
   output logic             y_valid,
   output logic [WIDTH-1:0] y_data,
   input  logic             y_ready,
   output logic             sel
);

   localparam int CW = $clog2(MAX_BURST + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_A = 2'd1,
      OWN_B = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             sel_q, sel_d;
   logic             y_valid_q, y_valid_d;
   logic [WIDTH-1:0] y_data_q, y_data_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             last_b_q, last_b_d;   // 1: B was served most recently

   logic             own_b;
   logic             own_valid;
   logic             oth_valid;
   logic [WIDTH-1:0] own_data;
   logic             own_rdy;
   logic             xfer;
   state_t           other_state;

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      y_valid_d   = y_valid_q;
      y_data_d    = y_data_q;
      cnt_d       = cnt_q;
      last_b_d    = last_b_q;
      a_ready     = 1'b0;
      b_ready     = 1'b0;
      xfer        = 1'b0;

      own_b       = (state_q == OWN_B);
      own_valid   = own_b ? b_valid : a_valid;
      oth_valid   = own_b ? a_valid : b_valid;
      own_data    = own_b ? b_data  : a_data;
      other_state = own_b ? OWN_A   : OWN_B;
      own_rdy     = ~y_valid_q | y_ready;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            // On a tie the source not served last wins.
            if (a_valid && (!b_valid || last_b_q)) begin
               state_d = OWN_A;
            end else if (b_valid) begin
               state_d = OWN_B;
            end
         end
         OWN_A, OWN_B: begin
            a_ready = !own_b && own_rdy;
            b_ready =  own_b && own_rdy;
            xfer    = own_valid && own_rdy;
            if (!own_valid) begin
               state_d = oth_valid ? other_state : IDLE;
               cnt_d   = '0;
            end else if (xfer) begin
               last_b_d = own_b;
               if (cnt_q == CW'(MAX_BURST - 1)) begin
                  // Burst limit: yield only if the other side is waiting.
                  cnt_d = '0;
                  if (oth_valid) begin
                     state_d = other_state;
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      if (xfer) begin
         y_data_d  = own_data;
         y_valid_d = 1'b1;
      end else if (y_valid_q && y_ready) begin
         y_valid_d = 1'b0;
      end

      if (state_d == OWN_A) begin
         sel_d = 1'b0;
      end else if (state_d == OWN_B) begin
         sel_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         sel_q     <= 1'b0;
         y_valid_q <= 1'b0;
         y_data_q  <= '0;
         cnt_q     <= '0;
         last_b_q  <= 1'b1;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         y_valid_q <= y_valid_d;
         y_data_q  <= y_data_d;
         cnt_q     <= cnt_d;
         last_b_q  <= last_b_d;
      end
   end

   assign y_valid = y_valid_q;
   assign y_data  = y_data_q;
   assign sel     = sel_q;

endmodule
